// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages and the stage register between them.
// Parameters: CTRL_W control-bundle width, DATA_W data-bundle width.
// Signals:    in_valid/in_ready/in_ctrl/in_data   upstream side
//             out_valid/out_ready/out_ctrl/out_data downstream side
// Modports:   slave  - the stage register (accepts upstream, presents downstream)
//             master - the surrounding stages (drive upstream, consume downstream)
interface pipe_skid_reg_if #(
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned DATA_W = 143
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a two-entry skid buffer and synchronous flush.
// Carries one control and one data bundle per beat over valid/ready; in_ready is
// a flop so no combinational path exists from out_ready back to in_ready.
// Ports: clk   - clock, rising edge
//        rst   - asynchronous active-high reset
//        flush - synchronous squash, leaves a bubble (control bits zero)
//        bus   - pipe_skid_reg_if.slave handshake bundle
// Build option: PIPE_SKID_REG_DATA_CLR_EN clears the data registers on rst and
// flush; when undefined the data registers have no reset and ignore flush.
module pipe_skid_reg #(
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned DATA_W = 143
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    pipe_skid_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              m_valid, m_valid_n;
    logic              in_ready_q, in_ready_n;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_n, s_ctrl, s_ctrl_n;
    logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
    logic              accept, pop;

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = m_valid & bus.out_ready;

    // State, valid and ready flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            m_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            m_valid    <= m_valid_n;
            in_ready_q <= in_ready_n;
        end
    end

    // Control bundles always clear so a bubble decodes as a NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl <= '0;
            s_ctrl <= '0;
        end else begin
            m_ctrl <= m_ctrl_n;
            s_ctrl <= s_ctrl_n;
        end
    end

`ifdef PIPE_SKID_REG_DATA_CLR_EN
    // Data bundles with reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            s_data <= '0;
        end else begin
            m_data <= m_data_n;
            s_data <= s_data_n;
        end
    end
`else
    // Data bundles without reset; contents are don't-care while out_valid is low
    always_ff @(posedge clk) begin
        m_data <= m_data_n;
        s_data <= s_data_n;
    end
`endif

    // Next-state and register loads
    always_comb begin
        state_n  = state;
        m_ctrl_n = m_ctrl;
        s_ctrl_n = s_ctrl;
        m_data_n = m_data;
        s_data_n = s_data;

        case (state)
            EMPTY: begin
                if (accept) begin
                    m_ctrl_n = bus.in_ctrl;
                    m_data_n = bus.in_data;
                    state_n  = FULL;
                end
            end
            FULL: begin
                if (pop && accept) begin
                    m_ctrl_n = bus.in_ctrl;
                    m_data_n = bus.in_data;
                end else if (pop) begin
                    m_ctrl_n = '0;
                    state_n  = EMPTY;
                end else if (accept) begin
                    s_ctrl_n = bus.in_ctrl;
                    s_data_n = bus.in_data;
                    state_n  = SKID;
                end
            end
            SKID: begin
                if (pop) begin
                    m_ctrl_n = s_ctrl;
                    m_data_n = s_data;
                    s_ctrl_n = '0;
                    state_n  = FULL;
                end
            end
            default: begin
                m_ctrl_n = '0;
                s_ctrl_n = '0;
                state_n  = EMPTY;
            end
        endcase

        // Flush overrides the handshake; a same-cycle pop has already been sampled
        if (flush) begin
            state_n  = EMPTY;
            m_ctrl_n = '0;
            s_ctrl_n = '0;
`ifdef PIPE_SKID_REG_DATA_CLR_EN
            m_data_n = '0;
            s_data_n = '0;
`endif
        end

        m_valid_n  = (state_n != EMPTY);
        in_ready_n = (state_n != SKID);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = m_valid;
    assign bus.out_ctrl  = m_ctrl;
    assign bus.out_data  = m_data;

endmodule
